// File: rtl/redmule_mx_slot_packer_if.sv
// hwpe-stream handshake bundle carrying packed MX beats towards the Z streamer.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, data, strb, input ready);
  modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/redmule_mx_slot_packer.sv
// Packs pairs of 256-bit FP8 result slots into 512-bit Z beats, exponents on a side port.
// Optional beat/stall performance counters are enabled by defining REDMULE_MX_PACKER_PERF_EN.

module redmule_mx_slot_packer_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_pop;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i & valid_o;
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  // NOTE: storage is deliberately not reset; data_o is masked while empty, so stale entries never leak.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      if (push_i && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push_i && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end
endmodule

module redmule_mx_slot_packer #(
  parameter int unsigned DATAW_ALIGN     = 512,
  parameter int unsigned MX_DATA_W       = 256,
  parameter int unsigned BEAT_FIFO_DEPTH = 2,
  parameter int unsigned EXP_FIFO_DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clear_i,
  input  logic                   mx_enable_i,
  input  logic                   slot_valid_i,
  output logic                   slot_ready_o,
  input  logic [MX_DATA_W-1:0]   slot_data_i,
  input  logic [7:0]             slot_exp_i,
  input  logic                   flush_i,
  hwpe_stream_intf_stream.source z_data_o,
  output logic                   exp_valid_o,
  input  logic                   exp_ready_i,
  output logic [7:0]             exp_data_o,
`ifdef REDMULE_MX_PACKER_PERF_EN
  output logic [31:0]            beat_cnt_o,
  output logic [31:0]            stall_cnt_o,
`endif
  output logic                   busy_o
);
  if (DATAW_ALIGN != 2 * MX_DATA_W) begin : g_bad_width
    $fatal(1, "DATAW_ALIGN must equal 2*MX_DATA_W");
  end
  if (BEAT_FIFO_DEPTH < 2) begin : g_bad_beat_depth
    $fatal(1, "BEAT_FIFO_DEPTH must be >= 2");
  end
  if (EXP_FIFO_DEPTH < 2 * BEAT_FIFO_DEPTH) begin : g_bad_exp_depth
    $fatal(1, "EXP_FIFO_DEPTH must be >= 2*BEAT_FIFO_DEPTH");
  end

  typedef enum logic {IDLE, HALF} state_e;

  state_e                 state_q, state_d;
  logic [MX_DATA_W-1:0]   half_q;
  logic                   half_load;
  logic                   slot_accept;
  logic                   beat_push, beat_pop, beat_full, beat_valid;
  logic [DATAW_ALIGN-1:0] beat_wdata, beat_head;
  logic                   exp_pop, exp_full;

  // A lone slot in IDLE only needs exponent room; anything that emits a beat also needs beat room.
  assign slot_ready_o = !exp_full && ((state_q == IDLE && mx_enable_i) || !beat_full);
  assign slot_accept  = slot_valid_i & slot_ready_o;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    half_load  = 1'b0;
    beat_push  = 1'b0;
    beat_wdata = '0;
    case (state_q)
      IDLE: begin
        if (slot_accept) begin
          if (mx_enable_i) begin
            half_load = 1'b1;
            state_d   = HALF;
          end else begin
            beat_push  = 1'b1;
            beat_wdata = {{(DATAW_ALIGN - MX_DATA_W){1'b0}}, slot_data_i};
          end
        end
      end
      HALF: begin
        if (slot_accept) begin
          beat_push  = 1'b1;
          beat_wdata = {slot_data_i, half_q};
          state_d    = IDLE;
        end else if (flush_i && !beat_full) begin
          beat_push  = 1'b1;
          beat_wdata = {{(DATAW_ALIGN - MX_DATA_W){1'b0}}, half_q};
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) state_q <= IDLE;
    else                    state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (half_load) half_q <= slot_data_i;
  end

  assign beat_pop = beat_valid & z_data_o.ready;

  redmule_mx_slot_packer_fifo #(
    .WIDTH (DATAW_ALIGN),
    .DEPTH (BEAT_FIFO_DEPTH)
  ) i_beat_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (beat_push),
    .data_i  (beat_wdata),
    .pop_i   (beat_pop),
    .full_o  (beat_full),
    .valid_o (beat_valid),
    .data_o  (beat_head)
  );

  assign exp_pop = exp_valid_o & exp_ready_i;

  // Exponents are pushed per accepted slot, so their order tracks slot order regardless of beat stalls.
  redmule_mx_slot_packer_fifo #(
    .WIDTH (8),
    .DEPTH (EXP_FIFO_DEPTH)
  ) i_exp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (slot_accept),
    .data_i  (slot_exp_i),
    .pop_i   (exp_pop),
    .full_o  (exp_full),
    .valid_o (exp_valid_o),
    .data_o  (exp_data_o)
  );

  assign z_data_o.valid = beat_valid;
  assign z_data_o.data  = beat_head;
  assign z_data_o.strb  = '1;

  assign busy_o = (state_q == HALF) | beat_valid | exp_valid_o;

`ifdef REDMULE_MX_PACKER_PERF_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      beat_cnt_o  <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (beat_pop && beat_cnt_o != '1) beat_cnt_o <= beat_cnt_o + 32'd1;
      if (slot_valid_i && !slot_ready_o && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
